// File: rtl/uart_ctrl_pkg.sv
// Shared constants and types for the UART command sequencer.
package uart_ctrl_pkg;

    localparam int unsigned OPC_W   = 8;
    localparam int unsigned STATE_W = 3;

    // Frame opcodes (first byte of every command frame)
    localparam logic [OPC_W-1:0] WR_CMD = 8'hAA;
    localparam logic [OPC_W-1:0] RD_CMD = 8'hBB;

    // Sequencer states
    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_W_ADDR  = 3'd1,
        S_W_DATA  = 3'd2,
        S_W_EXEC  = 3'd3,
        S_R_ADDR  = 3'd4,
        S_R_EXEC  = 3'd5,
        S_R_WAIT  = 3'd6,
        S_TX_SEND = 3'd7
    } state_e;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle between the command sequencer and the UART RX/TX + register file.
// master: the sequencer; slave: the surrounding UART and register-file logic.
interface uart_cmd_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              Rx_Data_valid;
    logic [DATA_W-1:0] Rx_P_Data;
    logic              Rx_Parity_error;
    logic              Rx_stop_error;

    logic [ADDR_W-1:0] RF_Addr;
    logic [DATA_W-1:0] RF_WrData;
    logic              RF_WrEn;
    logic              RF_RdEn;
    logic [DATA_W-1:0] RF_RdData;
    logic              RF_RdData_valid;

    logic [DATA_W-1:0] Tx_P_Data;
    logic              Tx_Data_valid;
    logic              Tx_busy;

    logic              Frame_error;
    logic              Busy;

    modport master (
        input  Rx_Data_valid, Rx_P_Data, Rx_Parity_error, Rx_stop_error,
        input  RF_RdData, RF_RdData_valid, Tx_busy,
        output RF_Addr, RF_WrData, RF_WrEn, RF_RdEn,
        output Tx_P_Data, Tx_Data_valid, Frame_error, Busy
    );

    modport slave (
        output Rx_Data_valid, Rx_P_Data, Rx_Parity_error, Rx_stop_error,
        output RF_RdData, RF_RdData_valid, Tx_busy,
        input  RF_Addr, RF_WrData, RF_WrEn, RF_RdEn,
        input  Tx_P_Data, Tx_Data_valid, Frame_error, Busy
    );

endinterface

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte gap counter for partial command frames.
// Only built when CMD_TIMEOUT_EN is defined; empty otherwise.
`ifdef CMD_TIMEOUT_EN
module cmd_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count;

    // Count enabled cycles since the last clear; flag once TIMEOUT_CYC is reached
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (enable && !expired) begin
            count   <= count + CNT_W'(1);
            expired <= (count == CNT_W'(TIMEOUT_CYC - 1));
        end
    end

endmodule
`endif

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer behind the UART receiver: assembles write (AA,addr,data)
// and read (BB,addr) frames, drives register-file strobes and returns read
// data through the UART transmitter.
// Optional feature: CMD_TIMEOUT_EN aborts partial frames after TIMEOUT_CYC
// idle cycles between bytes; without it partial frames wait indefinitely.
module uart_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4096
`endif
) (
    input logic             CLK,
    input logic             Reset,
    uart_cmd_ctrl_if.master bus
);

    localparam logic [STATE_W-1:0] IDLE    = STATE_W'(S_IDLE);
    localparam logic [STATE_W-1:0] W_ADDR  = STATE_W'(S_W_ADDR);
    localparam logic [STATE_W-1:0] W_DATA  = STATE_W'(S_W_DATA);
    localparam logic [STATE_W-1:0] W_EXEC  = STATE_W'(S_W_EXEC);
    localparam logic [STATE_W-1:0] R_ADDR  = STATE_W'(S_R_ADDR);
    localparam logic [STATE_W-1:0] R_EXEC  = STATE_W'(S_R_EXEC);
    localparam logic [STATE_W-1:0] R_WAIT  = STATE_W'(S_R_WAIT);
    localparam logic [STATE_W-1:0] TX_SEND = STATE_W'(S_TX_SEND);

    logic [STATE_W-1:0] state,       next_state;
    logic [ADDR_W-1:0]  rf_addr,     next_rf_addr;
    logic [DATA_W-1:0]  rf_wrdata,   next_rf_wrdata;
    logic               rf_wren,     next_rf_wren;
    logic               rf_rden,     next_rf_rden;
    logic [DATA_W-1:0]  rd_byte,     next_rd_byte;
    logic [DATA_W-1:0]  tx_data,     next_tx_data;
    logic               tx_valid,    next_tx_valid;
    logic               frame_error, next_frame_error;
    logic               busy,        next_busy;

    logic               rx_valid;
    logic [DATA_W-1:0]  rx_byte;
    logic               rx_bad;
    logic               addr_bad;
    logic               timeout;

    assign rx_valid = bus.Rx_Data_valid;
    assign rx_byte  = bus.Rx_P_Data;
    assign rx_bad   = bus.Rx_Parity_error | bus.Rx_stop_error;
    assign addr_bad = (rx_byte >> ADDR_W) != '0;

`ifdef CMD_TIMEOUT_EN
    logic tmo_enable;
    logic tmo_clear;

    // Gap counter runs only while a frame is partially received
    assign tmo_enable = (state == W_ADDR) || (state == W_DATA) || (state == R_ADDR);
    assign tmo_clear  = rx_valid || !tmo_enable;

    cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (CLK),
        .rst     (Reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Next-state and next-output decode; every abort/overrun cause ORs into one error pulse
    always_comb begin
        next_state       = state;
        next_rf_addr     = rf_addr;
        next_rf_wrdata   = rf_wrdata;
        next_rf_wren     = 1'b0;
        next_rf_rden     = 1'b0;
        next_rd_byte     = rd_byte;
        next_tx_data     = tx_data;
        next_tx_valid    = 1'b0;
        next_frame_error = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_bad) begin
                        next_frame_error = 1'b1;
                    end else if (rx_byte == DATA_W'(WR_CMD)) begin
                        next_state = W_ADDR;
                    end else if (rx_byte == DATA_W'(RD_CMD)) begin
                        next_state = R_ADDR;
                    end else begin
                        next_frame_error = 1'b1;
                    end
                end
            end

            W_ADDR: begin
                if (rx_valid) begin
                    if (rx_bad || addr_bad) begin
                        next_frame_error = 1'b1;
                        next_state       = IDLE;
                    end else begin
                        next_rf_addr = rx_byte[ADDR_W-1:0];
                        next_state   = W_DATA;
                    end
                end else if (timeout) begin
                    next_frame_error = 1'b1;
                    next_state       = IDLE;
                end
            end

            W_DATA: begin
                if (rx_valid) begin
                    if (rx_bad) begin
                        next_frame_error = 1'b1;
                        next_state       = IDLE;
                    end else begin
                        next_rf_wrdata = rx_byte;
                        next_rf_wren   = 1'b1;
                        next_state     = W_EXEC;
                    end
                end else if (timeout) begin
                    next_frame_error = 1'b1;
                    next_state       = IDLE;
                end
            end

            W_EXEC: begin
                next_frame_error = rx_valid;
                next_state       = IDLE;
            end

            R_ADDR: begin
                if (rx_valid) begin
                    if (rx_bad || addr_bad) begin
                        next_frame_error = 1'b1;
                        next_state       = IDLE;
                    end else begin
                        next_rf_addr = rx_byte[ADDR_W-1:0];
                        next_rf_rden = 1'b1;
                        next_state   = R_EXEC;
                    end
                end else if (timeout) begin
                    next_frame_error = 1'b1;
                    next_state       = IDLE;
                end
            end

            R_EXEC: begin
                next_frame_error = rx_valid;
                next_state       = R_WAIT;
            end

            R_WAIT: begin
                next_frame_error = rx_valid;
                if (bus.RF_RdData_valid) begin
                    next_rd_byte = bus.RF_RdData;
                    next_state   = TX_SEND;
                end
            end

            TX_SEND: begin
                next_frame_error = rx_valid;
                if (!bus.Tx_busy) begin
                    next_tx_data  = rd_byte;
                    next_tx_valid = 1'b1;
                    next_state    = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase

        next_busy = (next_state != IDLE);
    end

    // State and registered outputs; reset abandons any frame silently
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            rf_addr     <= '0;
            rf_wrdata   <= '0;
            rf_wren     <= 1'b0;
            rf_rden     <= 1'b0;
            rd_byte     <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            rf_addr     <= next_rf_addr;
            rf_wrdata   <= next_rf_wrdata;
            rf_wren     <= next_rf_wren;
            rf_rden     <= next_rf_rden;
            rd_byte     <= next_rd_byte;
            tx_data     <= next_tx_data;
            tx_valid    <= next_tx_valid;
            frame_error <= next_frame_error;
            busy        <= next_busy;
        end
    end

    assign bus.RF_Addr       = rf_addr;
    assign bus.RF_WrData     = rf_wrdata;
    assign bus.RF_WrEn       = rf_wren;
    assign bus.RF_RdEn       = rf_rden;
    assign bus.Tx_P_Data     = tx_data;
    assign bus.Tx_Data_valid = tx_valid;
    assign bus.Frame_error   = frame_error;
    assign bus.Busy          = busy;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames plus randomized frames checked
// against a register-file image kept by the bench.
module tb_uart_cmd_ctrl;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned TIMEOUT_CYC = 4096;

    logic CLK = 1'b0;
    logic Reset;

    uart_cmd_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    uart_cmd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int ferr_cnt = 0;
    int wren_cnt = 0;
    int rden_cnt = 0;
    int txv_cnt  = 0;

    int         rd_lat = 1;
    int         rd_cd  = 0;
    logic [3:0] rd_addr_q;

    logic [7:0] rf_mem  [16];
    logic [7:0] ref_mem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic perr = 1'b0, input logic serr = 1'b0);
        bus.Rx_P_Data       = b;
        bus.Rx_Parity_error = perr;
        bus.Rx_stop_error   = serr;
        bus.Rx_Data_valid   = 1'b1;
        tick(1);
        bus.Rx_Data_valid   = 1'b0;
        bus.Rx_Parity_error = 1'b0;
        bus.Rx_stop_error   = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.RF_Addr, bus.RF_WrData, bus.RF_WrEn, bus.RF_RdEn,
                    bus.Tx_P_Data, bus.Tx_Data_valid, bus.Frame_error, bus.Busy});
    endfunction

    // Event counters sampled mid-cycle
    initial forever begin
        @(negedge CLK);
        if (bus.Frame_error)   ferr_cnt++;
        if (bus.RF_WrEn)       wren_cnt++;
        if (bus.RF_RdEn)       rden_cnt++;
        if (bus.Tx_Data_valid) txv_cnt++;
    end

    // Register file: writes on RF_WrEn, read data rd_lat cycles after RF_RdEn
    initial begin
        bus.RF_RdData       = '0;
        bus.RF_RdData_valid = 1'b0;
        forever begin
            @(negedge CLK);
            bus.RF_RdData_valid = 1'b0;
            if (bus.RF_WrEn) rf_mem[bus.RF_Addr] = bus.RF_WrData;
            if (bus.RF_RdEn) begin
                rd_cd     = rd_lat;
                rd_addr_q = bus.RF_Addr;
            end else if (rd_cd > 0) begin
                rd_cd--;
                if (rd_cd == 0) begin
                    bus.RF_RdData       = rf_mem[rd_addr_q];
                    bus.RF_RdData_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        int         f0, w0, r0, t0, n, got;
        logic [3:0] a;
        logic [7:0] d, txd;

        bus.Rx_Data_valid   = 1'b0;
        bus.Rx_P_Data       = '0;
        bus.Rx_Parity_error = 1'b0;
        bus.Rx_stop_error   = 1'b0;
        bus.Tx_busy         = 1'b0;
        Reset               = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rf_mem[i]  = 8'($urandom);
            ref_mem[i] = rf_mem[i];
        end

        tick(3);
        chk("reset_outputs", outs(), 0);
        Reset = 1'b0;
        tick(1);
        chk("idle_after_reset", outs(), 0);

        // 1: write AA,03,5C
        f0 = ferr_cnt; w0 = wren_cnt;
        send_byte(8'hAA);
        chk("t1_busy", 32'(bus.Busy), 1);
        send_byte(8'h03);
        send_byte(8'h5C);
        chk("t1_wren", 32'(bus.RF_WrEn), 1);
        chk("t1_addr", 32'(bus.RF_Addr), 'h3);
        chk("t1_wrdata", 32'(bus.RF_WrData), 'h5C);
        ref_mem[3] = 8'h5C;
        tick(1);
        chk("t1_wren_one_cycle", 32'(bus.RF_WrEn), 0);
        chk("t1_idle", 32'(bus.Busy), 0);
        chk("t1_wren_count", wren_cnt - w0, 1);
        chk("t1_no_ferr", ferr_cnt - f0, 0);

        // 2: read BB,07 with latency 2 and TX busy for 10 cycles
        rf_mem[7] = 8'hC3; ref_mem[7] = 8'hC3;
        rd_lat = 2;
        bus.Tx_busy = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h07);
        chk("t2_rden", 32'(bus.RF_RdEn), 1);
        chk("t2_addr", 32'(bus.RF_Addr), 'h7);
        t0 = txv_cnt;
        tick(10);
        chk("t2_no_tx_while_busy", txv_cnt - t0, 0);
        chk("t2_addr_held", 32'(bus.RF_Addr), 'h7);
        chk("t2_still_busy", 32'(bus.Busy), 1);
        bus.Tx_busy = 1'b0;
        chk("t2_tx_not_yet", 32'(bus.Tx_Data_valid), 0);
        tick(1);
        chk("t2_tx_valid", 32'(bus.Tx_Data_valid), 1);
        chk("t2_tx_data", 32'(bus.Tx_P_Data), 'hC3);
        tick(1);
        chk("t2_tx_one_cycle", 32'(bus.Tx_Data_valid), 0);
        chk("t2_tx_data_held", 32'(bus.Tx_P_Data), 'hC3);
        chk("t2_idle", 32'(bus.Busy), 0);

        // 3: parity error on address byte aborts the write
        f0 = ferr_cnt; w0 = wren_cnt;
        send_byte(8'hAA);
        send_byte(8'h03, 1'b1, 1'b0);
        chk("t3_ferr", 32'(bus.Frame_error), 1);
        chk("t3_idle", 32'(bus.Busy), 0);
        tick(2);
        chk("t3_ferr_pulse", ferr_cnt - f0, 1);
        chk("t3_no_wren", wren_cnt - w0, 0);

        // stop error on a read address byte aborts the read
        r0 = rden_cnt;
        send_byte(8'hBB);
        send_byte(8'h04, 1'b0, 1'b1);
        chk("t3b_ferr", 32'(bus.Frame_error), 1);
        tick(2);
        chk("t3b_no_rden", rden_cnt - r0, 0);

        // 4: bad opcode, then out-of-range read address
        send_byte(8'h5A);
        chk("t4_bad_opcode_ferr", 32'(bus.Frame_error), 1);
        chk("t4_bad_opcode_idle", 32'(bus.Busy), 0);
        r0 = rden_cnt;
        send_byte(8'hBB);
        send_byte(8'h12);
        chk("t4_bad_addr_ferr", 32'(bus.Frame_error), 1);
        chk("t4_bad_addr_idle", 32'(bus.Busy), 0);
        tick(3);
        chk("t4_no_rden", rden_cnt - r0, 0);

        // overrun during W_EXEC: byte dropped, write still completes
        f0 = ferr_cnt; w0 = wren_cnt;
        d = 8'($urandom);
        send_byte(8'hAA);
        send_byte(8'h09);
        send_byte(d);
        send_byte(8'hAA);
        chk("ovr_ferr", 32'(bus.Frame_error), 1);
        chk("ovr_idle", 32'(bus.Busy), 0);
        ref_mem[9] = d;
        tick(1);
        chk("ovr_wren_count", wren_cnt - w0, 1);
        chk("ovr_ferr_count", ferr_cnt - f0, 1);

        // 5: gap after address byte
        f0 = ferr_cnt; w0 = wren_cnt;
        send_byte(8'hAA);
        send_byte(8'h01);
`ifdef CMD_TIMEOUT_EN
        n = 0; got = 0;
        while (!got && n < int'(TIMEOUT_CYC) + 10) begin
            tick(1);
            n++;
            if (bus.Frame_error) got = 1;
        end
        chk("t5_timeout_seen", got, 1);
        chk("t5_timeout_cycles", n, TIMEOUT_CYC + 1);
        chk("t5_timeout_idle", 32'(bus.Busy), 0);
        tick(1);
        chk("t5_no_wren", wren_cnt - w0, 0);
`else
        tick(int'(TIMEOUT_CYC) + 10);
        chk("t5_still_waiting", 32'(bus.Busy), 1);
        chk("t5_no_ferr", ferr_cnt - f0, 0);
        d = 8'($urandom);
        send_byte(d);
        chk("t5_late_wren", 32'(bus.RF_WrEn), 1);
        chk("t5_late_addr", 32'(bus.RF_Addr), 'h1);
        chk("t5_late_data", 32'(bus.RF_WrData), 32'(d));
        ref_mem[1] = d;
        tick(1);
`endif

        // 6: reset in W_DATA and in R_WAIT
        f0 = ferr_cnt; w0 = wren_cnt;
        send_byte(8'hAA);
        send_byte(8'h02);
        Reset = 1'b1;
        tick(1);
        chk("t6_wdata_reset_outs", outs(), 0);
        Reset = 1'b0;
        send_byte(8'h33);
        tick(2);
        chk("t6_wdata_no_wren", wren_cnt - w0, 0);

        rd_lat = 30;
        send_byte(8'hBB);
        send_byte(8'h05);
        tick(2);
        chk("t6_in_rwait", 32'(bus.Busy), 1);
        f0 = ferr_cnt; t0 = txv_cnt;
        Reset = 1'b1;
        tick(1);
        chk("t6_rwait_reset_outs", outs(), 0);
        Reset = 1'b0;
        tick(35);
        chk("t6_rwait_no_tx", txv_cnt - t0, 0);
        chk("t6_rwait_no_ferr", ferr_cnt - f0, 0);
        chk("t6_rwait_idle", 32'(bus.Busy), 0);

        // randomized frames against the register image
        for (int i = 0; i < 30; i++) begin
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    send_byte(8'hAA);
                    tick($urandom_range(0, 2));
                    send_byte(8'(a));
                    tick($urandom_range(0, 2));
                    send_byte(d);
                    chk("rnd_wren", 32'(bus.RF_WrEn), 1);
                    chk("rnd_wr_addr", 32'(bus.RF_Addr), 32'(a));
                    chk("rnd_wr_data", 32'(bus.RF_WrData), 32'(d));
                    ref_mem[a] = d;
                    tick(1);
                end
                1: begin
                    rd_lat = $urandom_range(1, 5);
                    send_byte(8'hBB);
                    tick($urandom_range(0, 2));
                    send_byte(8'(a));
                    chk("rnd_rden", 32'(bus.RF_RdEn), 1);
                    got = 0; txd = '0;
                    for (int k = 0; k < 20 && got == 0; k++) begin
                        tick(1);
                        if (bus.Tx_Data_valid) begin
                            got = 1;
                            txd = bus.Tx_P_Data;
                        end
                    end
                    chk("rnd_tx_seen", got, 1);
                    chk("rnd_tx_data", 32'(txd), 32'(ref_mem[a]));
                end
                default: begin
                    if (d == 8'hAA || d == 8'hBB) d = 8'h00;
                    send_byte(d);
                    chk("rnd_bad_opcode", 32'(bus.Frame_error), 1);
                    tick(1);
                end
            endcase
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
